// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and width limits.
package serial_add_ctrl_pkg;

  localparam int unsigned SADD_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } sadd_state_e;

  // Bit counter is one bit wider than strictly needed so WIDTH=1 still gets a real register.
  function automatic int unsigned sadd_cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder cell shared by the serial adder controller. Purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);

  always_comb begin
    sum  = a ^ b ^ c;
    cout = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: sequences one full_adder over WIDTH cycles, LSB first.
// Optional signed-overflow output ovf_o is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf_o,
`endif
  output logic             cout_o
);

  localparam int unsigned CntW = sadd_cnt_width(WIDTH);

  sadd_state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] res_shift;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .c    (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign accept   = (state_q == StIdle) && start_i;
  assign last_bit = (state_q == StRun) && (cnt_q == CntW'(WIDTH - 1));

  // New result bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  if (WIDTH == 1) begin : gen_res_w1
    assign res_shift = fa_sum;
  end else begin : gen_res_wn
    assign res_shift = {fa_sum, res_sh_q[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_i) state_d = StRun;
      StRun:  if (last_bit) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    unique case (state_q)
      StIdle: ;
      StRun:  busy_o = 1'b1;
      StDone: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    if (accept) begin
      a_sh_d  = op_a_i;
      b_sh_d  = op_b_i;
      carry_d = cin_i;
      cnt_d   = '0;
    end else if (state_q == StRun) begin
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      res_sh_d = res_shift;
      carry_d  = fa_cout;
      cnt_d    = cnt_q + CntW'(1);
      if (last_bit) begin
        sum_d  = res_shift;
        cout_d = fa_cout;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q, ovf_d;

  // During the last RUN cycle carry_q is the carry into the MSB and fa_cout the carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (last_bit) ovf_d = carry_q ^ fa_cout;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus random ops vs. an arithmetic model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
  logic         s1_ovf;
`endif

  logic         s1_start;
  logic [0:0]   s1_a, s1_b;
  logic         s1_cin;
  logic         s1_busy, s1_done, s1_cout;
  logic [0:0]   s1_sum;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) u_dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .op_a_i  (op_a),
    .op_b_i  (op_b),
    .cin_i   (cin),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
`ifdef SERIAL_ADD_OVF_EN
    .ovf_o   (ovf),
`endif
    .cout_o  (cout)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut_w1 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (s1_start),
    .op_a_i  (s1_a),
    .op_b_i  (s1_b),
    .cin_i   (s1_cin),
    .busy_o  (s1_busy),
    .done_o  (s1_done),
    .sum_o   (s1_sum),
`ifdef SERIAL_ADD_OVF_EN
    .ovf_o   (s1_ovf),
`endif
    .cout_o  (s1_cout)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation; with noise, inputs and start toggle randomly after capture.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input bit noise, input string tag);
    logic [W:0] exp;
    int n;
    exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    @(negedge clk);
    op_a = a; op_b = b; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      check_eq({tag, " busy_run"}, 64'(busy), 64'd1);
      if (noise) begin
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        cin   = 1'($urandom);
        start = (n < W) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check_eq({tag, " latency"}, 64'(n), 64'(W + 1));
    check_eq({tag, " sum"}, 64'(sum), 64'(exp[W-1:0]));
    check_eq({tag, " cout"}, 64'(cout), 64'(exp[W]));
    check_eq({tag, " busy_done"}, 64'(busy), 64'd1);
`ifdef SERIAL_ADD_OVF_EN
    begin
      int ss;
      ss = int'($signed(a)) + int'($signed(b)) + int'(ci);
      check_eq({tag, " ovf"}, 64'(ovf), 64'((ss > 127 || ss < -128) ? 1 : 0));
    end
`endif
    @(negedge clk);
    check_eq({tag, " done_pulse"}, 64'(done), 64'd0);
    check_eq({tag, " idle_busy"}, 64'(busy), 64'd0);
    check_eq({tag, " sum_hold"}, 64'(sum), 64'(exp[W-1:0]));
    check_eq({tag, " cout_hold"}, 64'(cout), 64'(exp[W]));
  endtask

  task automatic run_op1(input logic a, input logic b, input logic ci);
    int n;
    int total;
    total = int'(a) + int'(b) + int'(ci);
    @(negedge clk);
    s1_a = a; s1_b = b; s1_cin = ci; s1_start = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    n = 1;
    while (!s1_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("w1 latency", 64'(n), 64'd2);
    check_eq("w1 sum", 64'(s1_sum), 64'(total % 2));
    check_eq("w1 cout", 64'(s1_cout), 64'(total / 2));
  endtask

  initial begin
    int dones, t1, t2;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst busy", 64'(busy), 64'd0);
    check_eq("rst done", 64'(done), 64'd0);
    check_eq("rst sum", 64'(sum), 64'd0);
    check_eq("rst cout", 64'(cout), 64'd0);
    check_eq("rst w1 busy", 64'(s1_busy), 64'd0);
    rst_n = 1'b1;

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, "t1");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, "t2a");
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, "t2b");

    // Held start: accepted every WIDTH+2 cycles, op_a glitch after capture must not matter.
    @(negedge clk);
    op_a = 8'h01; op_b = 8'h02; cin = 1'b0; start = 1'b1;
    dones = 0; t1 = 0; t2 = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 3) op_a = 8'hAA;
      if (n == 5) op_a = 8'h01;
      if (n == 20) start = 1'b0;
      if (done) begin
        dones++;
        if (dones == 1) t1 = n;
        else if (dones == 2) t2 = n;
        check_eq("t3 sum", 64'(sum), 64'h03);
      end
    end
    check_eq("t3 done count", 64'(dones), 64'd2);
    check_eq("t3 first done", 64'(t1), 64'd9);
    check_eq("t3 second done", 64'(t2), 64'd19);

    // Mid-operation reset aborts without a done pulse.
    @(negedge clk);
    op_a = 8'h12; op_b = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t4 busy", 64'(busy), 64'd0);
    check_eq("t4 done", 64'(done), 64'd0);
    check_eq("t4 sum", 64'(sum), 64'd0);
    check_eq("t4 cout", 64'(cout), 64'd0);
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n == 2) rst_n = 1'b1;
      if (done) dones++;
    end
    check_eq("t4 no done", 64'(dones), 64'd0);
    run_op(8'h12, 8'h34, 1'b1, 1'b0, "t4 after");

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run_op1(v[2], v[1], v[0]);
    end

    run_op(8'h7F, 8'h01, 1'b0, 1'b0, "t6a");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, "t6b");
    run_op(8'h80, 8'h80, 1'b0, 1'b0, "t6c");

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
